// File: rtl/alu_1b_if.sv
// Operand/result bundle for one alu_1b slice.
// Optional SLT feedback signals (less, set) exist only when ALU1B_SLT_EN is defined.
interface alu_1b_if;
  logic a;
  logic b;
  logic a_inv;
  logic b_inv;
  logic c_in;
  logic s1;
  logic s0;
  logic x;
  logic c_out;
`ifdef ALU1B_SLT_EN
  logic less;
  logic set;
`endif

`ifdef ALU1B_SLT_EN
  modport master (
    output a, b, a_inv, b_inv, c_in, s1, s0, less,
    input  x, c_out, set
  );
  modport slave (
    input  a, b, a_inv, b_inv, c_in, s1, s0, less,
    output x, c_out, set
  );
`else
  modport master (
    output a, b, a_inv, b_inv, c_in, s1, s0,
    input  x, c_out
  );
  modport slave (
    input  a, b, a_inv, b_inv, c_in, s1, s0,
    output x, c_out
  );
`endif
endinterface

// File: rtl/alu_1b.sv
// One-bit ALU slice with registered result and carry-out.
// Ops {s1,s0}: 00 AND, 01 OR, 10 ADD, 11 XOR (or "less" when ALU1B_SLT_EN is defined).
// Optional feature macro: ALU1B_SLT_EN adds the less input and registered set (raw sum) output.
module alu_1b (
  input  logic     clk,
  input  logic     rst,
  alu_1b_if.slave  bus
);

  logic a_p;
  logic b_p;
  logic sum;
  logic carry;
  logic res;
  logic x_q;
  logic c_out_q;
`ifdef ALU1B_SLT_EN
  logic set_q;
`endif

  // Operand conditioning, full adder and result select.
  always_comb begin
    a_p   = bus.a ^ bus.a_inv;
    b_p   = bus.b ^ bus.b_inv;
    sum   = a_p ^ b_p ^ bus.c_in;
    carry = (a_p & b_p) | (a_p & bus.c_in) | (b_p & bus.c_in);
    res   = 1'b0;
    case ({bus.s1, bus.s0})
      2'b00:   res = a_p & b_p;
      2'b01:   res = a_p | b_p;
      2'b10:   res = sum;
`ifdef ALU1B_SLT_EN
      default: res = bus.less;
`else
      default: res = a_p ^ b_p;
`endif
    endcase
  end

  // Output registers; carry loads on every op so a ripple chain stays consistent.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= 1'b0;
      c_out_q <= 1'b0;
`ifdef ALU1B_SLT_EN
      set_q   <= 1'b0;
`endif
    end else begin
      x_q     <= res;
      c_out_q <= carry;
`ifdef ALU1B_SLT_EN
      set_q   <= sum;
`endif
    end
  end

  assign bus.x     = x_q;
  assign bus.c_out = c_out_q;
`ifdef ALU1B_SLT_EN
  assign bus.set   = set_q;
`endif

endmodule

// File: tb/tb_alu_1b.sv
// Scoreboard bench for alu_1b: the driver pushes hand-computed expectations,
// a monitor pops one per cycle after the capturing edge and compares.
module tb_alu_1b;

  typedef struct {
    logic       rst;
    logic       a;
    logic       b;
    logic       ai;
    logic       bi;
    logic       ci;
    logic [1:0] op;
    logic       less;
    logic       ex;
    logic       ec;
    logic       es;
  } vec_t;

  typedef struct {
    int   idx;
    logic ex;
    logic ec;
    logic es;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];
  vec_t vecs[19];

  alu_1b_if bus ();

  alu_1b dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic a, input logic b,
                              input logic ai, input logic bi, input logic ci,
                              input logic [1:0] op, input logic less,
                              input logic ex, input logic ec, input logic es);
    vec_t v;
    v.rst = r; v.a = a; v.b = b; v.ai = ai; v.bi = bi; v.ci = ci;
    v.op = op; v.less = less; v.ex = ex; v.ec = ec; v.es = es;
    return v;
  endfunction

  // Monitor: one expectation retires per capturing edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.x !== e.ex) begin
          errors++;
          $display("FAIL x[%0d]: got %b expected %b", e.idx, bus.x, e.ex);
        end
        checks++;
        if (bus.c_out !== e.ec) begin
          errors++;
          $display("FAIL c_out[%0d]: got %b expected %b", e.idx, bus.c_out, e.ec);
        end
`ifdef ALU1B_SLT_EN
        checks++;
        if (bus.set !== e.es) begin
          errors++;
          $display("FAIL set[%0d]: got %b expected %b", e.idx, bus.set, e.es);
        end
`endif
      end
    end
  end

  initial begin
    exp_t e;
    int   wait_cyc;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.a = 0; bus.b = 0; bus.a_inv = 0; bus.b_inv = 0;
    bus.c_in = 0; bus.s1 = 0; bus.s0 = 0;
`ifdef ALU1B_SLT_EN
    bus.less = 0;
`endif
    //              rst a  b  ai bi ci op     less x  c  set
    vecs[0]  = mk(1, 1, 1, 0, 0, 1, 2'b10, 0,   0, 0, 0); // reset wins
    vecs[1]  = mk(0, 1, 1, 0, 0, 1, 2'b10, 0,   1, 1, 1); // first load
    vecs[2]  = mk(0, 1, 0, 0, 0, 0, 2'b00, 0,   0, 0, 1); // AND
    vecs[3]  = mk(0, 1, 1, 0, 0, 0, 2'b00, 0,   1, 1, 0);
    vecs[4]  = mk(0, 1, 0, 0, 0, 0, 2'b01, 0,   1, 0, 1); // OR
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 2'b01, 0,   0, 0, 0);
    vecs[6]  = mk(0, 1, 0, 0, 0, 0, 2'b10, 0,   1, 0, 1); // ADD
    vecs[7]  = mk(0, 1, 1, 0, 0, 0, 2'b10, 0,   0, 1, 0);
    vecs[8]  = mk(0, 1, 1, 0, 0, 1, 2'b10, 0,   1, 1, 1);
    vecs[9]  = mk(0, 1, 1, 0, 1, 1, 2'b10, 0,   0, 1, 0); // SUB 1-1
    vecs[10] = mk(0, 0, 0, 1, 1, 0, 2'b00, 0,   1, 1, 0); // NOR
    vecs[11] = mk(0, 1, 0, 0, 0, 0, 2'b11, 1,   1, 0, 1); // op11
    vecs[12] = mk(0, 1, 1, 0, 0, 0, 2'b11, 0,   0, 1, 0);
    vecs[13] = mk(0, 1, 1, 0, 0, 0, 2'b00, 0,   1, 1, 0); // back-to-back
    vecs[14] = mk(0, 1, 1, 0, 0, 0, 2'b01, 0,   1, 1, 0);
    vecs[15] = mk(0, 1, 1, 0, 0, 0, 2'b10, 0,   0, 1, 0);
    vecs[16] = mk(0, 1, 1, 0, 0, 0, 2'b11, 0,   0, 1, 0);
    vecs[17] = mk(1, 1, 1, 0, 0, 1, 2'b10, 1,   0, 0, 0); // mid-stream reset
    vecs[18] = mk(0, 0, 1, 0, 0, 1, 2'b10, 0,   0, 1, 0);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      rst       = vecs[i].rst;
      bus.a     = vecs[i].a;
      bus.b     = vecs[i].b;
      bus.a_inv = vecs[i].ai;
      bus.b_inv = vecs[i].bi;
      bus.c_in  = vecs[i].ci;
      bus.s1    = vecs[i].op[1];
      bus.s0    = vecs[i].op[0];
`ifdef ALU1B_SLT_EN
      bus.less  = vecs[i].less;
`endif
      e.idx = i;
      e.ex  = vecs[i].ex;
      e.ec  = vecs[i].ec;
      e.es  = vecs[i].es;
      sb.push_back(e);
    end

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
